// File: rtl/idexe_pkg.sv
// Shared types for the ID->EXE handshake stage: control bundle layout, FSM states, widths.
package idexe_pkg;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic pc_en;
        logic jenable;
        logic jop_lsb;
        logic mux_mem;
        logic mux_exe;
        logic wr_mem_en;
        logic rd_mem_en;
        logic wb_en;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/idexe_perf_cnt.sv
// Two saturating event counters (backpressure cycles, effective flushes), cleared by rst only.
module idexe_perf_cnt
    import idexe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_evt,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_INC;
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_INC;
        end
    end

endmodule

// File: rtl/idexe_pipe_hs.sv
// ID->EXE pipeline stage: valid/ready handshake, 2-entry skid buffer, flush bubbles.
// Optional IDEXE_PERF_CNT_EN adds stall_cnt/flush_cnt ports and counters.
module idexe_pipe_hs
    import idexe_pkg::*;
#(
    parameter int ARQ     = 16,
    parameter int JADDR_W = 13,
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = idexe_pkg::CTRL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  ctrl_in,
    input  logic [ARQ-1:0]     src1_in,
    input  logic [ARQ-1:0]     src2_in,
    input  logic [ARQ-1:0]     srcdest_in,
    input  logic [ARQ-1:0]     imm_in,
    input  logic [ALUOP_W-1:0] alu_op_in,
    input  logic [JADDR_W-1:0] jaddr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [ARQ-1:0]     src1_out,
    output logic [ARQ-1:0]     src2_out,
    output logic [ARQ-1:0]     srcdest_out,
    output logic [ARQ-1:0]     imm_out,
    output logic [ALUOP_W-1:0] alu_op_out,
    output logic [JADDR_W-1:0] jaddr_out
`ifdef IDEXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    localparam int PW = CTRL_W + 4*ARQ + ALUOP_W + JADDR_W;

    state_t        state_q, state_d;
    logic [PW-1:0] main_q, skid_q, pay_in;
    logic [CTRL_W-1:0] main_ctrl;
    logic          in_fire, out_fire;
    logic          ld_main_in, ld_main_skid, ld_skid;

    assign pay_in = {ctrl_in, src1_in, src2_in, srcdest_in, imm_in, alu_op_in, jaddr_in};

    assign in_ready  = (state_q != FULL) & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops every buffered beat but leaves the payload registers untouched;
        // a same-cycle in_fire still handshakes, its data simply never lands.
        if (flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_main_in)
                main_q <= pay_in;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= pay_in;
        end
    end

    assign {main_ctrl, src1_out, src2_out, srcdest_out, imm_out, alu_op_out, jaddr_out} = main_q;
    assign ctrl_out = out_valid ? main_ctrl : '0;

`ifdef IDEXE_PERF_CNT_EN
    idexe_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .stall_evt (out_valid & ~out_ready),
        .flush_evt (flush & (state_q != EMPTY)),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    // Counters absent: datapath and handshake are identical to the counted build.
`endif

endmodule
